// File: rtl/sys_defs.sv
// Shared definitions for the Output SRAM banks.
// Holds the request op encoding, the request/response packet layouts at the
// default bank geometry (16-bit feature values, 256 words, 4-bit tags), and
// the bank controller state encoding exposed on the debug port.
package sys_defs;

  localparam int OSB_FV_W  = 16;
  localparam int OSB_AW    = 8;
  localparam int OSB_TAG_W = 4;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RD  = 2'b01,
    OP_WR  = 2'b10,
    OP_ACC = 2'b11   // read-add-write, signed saturating
  } osb_op_e;

  typedef struct packed {
    osb_op_e               op;
    logic [OSB_AW-1:0]     addr;
    logic [OSB_FV_W-1:0]   wdata;
    logic [OSB_TAG_W-1:0]  tag;
  } osb_req_t;

  typedef struct packed {
    logic [OSB_FV_W-1:0]   data;
    logic [OSB_TAG_W-1:0]  tag;
  } osb_rsp_t;

  typedef enum logic [1:0] {
    BANK_INIT  = 2'b00,
    BANK_RUN   = 2'b01,
    BANK_DRAIN = 2'b10
  } bank_state_e;

endpackage

// File: rtl/sram_1r1w.sv
// Simple dual-port storage: one synchronous read port (1-cycle latency) and
// one write port. A same-cycle read of the address being written returns the
// old contents; callers that need the new value forward it themselves.
// Ports: clk; re/raddr/rdata read port; we/waddr/wdata write port.
module sram_1r1w #(
  parameter int W     = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/output_sram_bank_resp.sv
// One Output SRAM bank with read/write/accumulate requests and an in-order
// read-response FIFO.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req_*                 arbiter-granted request (op, addr, wdata, tag)
//   req_ready             bank can take a request this cycle
//   rsp_valid/data/tag    head of the read-response FIFO
//   rsp_ready             requester consumes the head entry
//   clear_start           pulse: drain, then zero the whole bank
//   init_done             pulse: zeroing finished, bank is back in service
//   dbg_state             controller state
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits for ready, and the response payload holds steady
// while rsp_valid && !rsp_ready. A NOP with valid is consumed with no effect.
module output_sram_bank_resp
  import sys_defs::*;
#(
  parameter int FV_W      = 16,
  parameter int DEPTH     = 256,
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [1:0]               req_op,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [FV_W-1:0]          req_wdata,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [FV_W-1:0]          rsp_data,
  output logic [TAG_W-1:0]         rsp_tag,
  input  logic                     rsp_ready,
  input  logic                     clear_start,
  output logic                     init_done,
  output bank_state_e              dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = FV_W + TAG_W;

  bank_state_e     state, state_nxt;
  logic [AW-1:0]   init_cnt;
  logic            init_last;
  logic            init_done_q;

  osb_op_e         op_in;
  logic            accept;
  logic            rd_issue;

  logic            s1_valid;
  osb_op_e         s1_op;
  logic [AW-1:0]   s1_addr;
  logic [FV_W-1:0] s1_wdata;
  logic [TAG_W-1:0] s1_tag;
  logic            s1_fwd;
  logic [FV_W-1:0] s1_fwd_data;
  logic [FV_W-1:0] sram_rdata;
  logic [FV_W-1:0] s1_operand;
  logic [FV_W:0]   sum_ext;
  logic [FV_W-1:0] acc_sum;
  logic [FV_W-1:0] s1_wr_data;
  logic            s1_we;
  logic            s1_rd;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [FV_W-1:0] mem_wdata;

  logic [EW-1:0]   fifo_mem [RSP_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic [CW:0]     fill;
  logic            push, pop;

  // ---------------- controller ----------------
  assign init_last = (state == BANK_INIT) && (init_cnt == AW'(DEPTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      BANK_INIT:  if (init_last) state_nxt = BANK_RUN;
      BANK_RUN:   if (clear_start) state_nxt = BANK_DRAIN;
      BANK_DRAIN: if (!s1_valid && (fifo_cnt == '0)) state_nxt = BANK_INIT;
      default:    state_nxt = BANK_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BANK_INIT;
      init_cnt    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      init_done_q <= init_last;
      init_cnt    <= (state == BANK_INIT) ? init_cnt + 1'b1 : '0;
    end
  end

  assign init_done = init_done_q;
  assign dbg_state = state;

  // ---------------- S0: accept and issue ----------------
  // A read sitting in S1 will occupy a FIFO slot next cycle, so it is counted
  // against the FIFO capacity now.
  assign op_in     = osb_op_e'(req_op);
  assign fill      = {1'b0, fifo_cnt} + {{CW{1'b0}}, s1_rd};
  assign req_ready = (state == BANK_RUN) && (fill < (CW+1)'(RSP_DEPTH));
  assign accept    = req_valid && req_ready && (op_in != OP_NOP);
  assign rd_issue  = accept && ((op_in == OP_RD) || (op_in == OP_ACC));

  // ---------------- S1: read data, accumulate, respond ----------------
  // Both WR and ACC commit through the single write port from S1, so they can
  // never collide, and a WR that follows an ACC to the same word lands last.
  // The value S1 commits this cycle is not visible to the S0 read issued this
  // cycle, so it is captured alongside the request and used instead.
  always_comb begin
    s1_operand = s1_fwd ? s1_fwd_data : sram_rdata;
    sum_ext    = {s1_operand[FV_W-1], s1_operand} + {s1_wdata[FV_W-1], s1_wdata};
    acc_sum    = sum_ext[FV_W-1:0];
    if (sum_ext[FV_W] != sum_ext[FV_W-1])
      acc_sum = sum_ext[FV_W] ? {1'b1, {(FV_W-1){1'b0}}} : {1'b0, {(FV_W-1){1'b1}}};
    s1_wr_data = (s1_op == OP_WR) ? s1_wdata : acc_sum;
  end

  assign s1_we = s1_valid && ((s1_op == OP_WR) || (s1_op == OP_ACC));
  assign s1_rd = s1_valid && (s1_op == OP_RD);

  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op       <= op_in;
      s1_addr     <= req_addr;
      s1_wdata    <= req_wdata;
      s1_tag      <= req_tag;
      s1_fwd      <= s1_we && (s1_addr == req_addr);
      s1_fwd_data <= s1_wr_data;
    end
  end

  // INIT owns the write port; S1 is always empty while zeroing.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s1_addr;
    mem_wdata = s1_wr_data;
    if (state == BANK_INIT) begin
      mem_we    = !reset;
      mem_waddr = init_cnt;
      mem_wdata = '0;
    end else begin
      mem_we    = s1_we && !reset;
    end
  end

  sram_1r1w #(.W(FV_W), .DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk   (clk),
    .re    (rd_issue),
    .raddr (req_addr),
    .rdata (sram_rdata),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata)
  );

  // ---------------- response FIFO ----------------
  assign push = s1_rd;
  assign pop  = (fifo_cnt != '0) && rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {s1_operand, s1_tag};
  end

  assign rsp_valid           = (fifo_cnt != '0);
  assign {rsp_data, rsp_tag} = rsp_valid ? fifo_mem[rd_ptr] : '0;

endmodule
